// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the MIPS datapath (slave).
// The mem_ready handshake exists only when MC_WAIT_STATE_EN is defined.
interface mc_control_fsm_if #(
   parameter int OPW = 6,
   parameter int SW  = 4
);
   logic [OPW-1:0] op;
   logic [OPW-1:0] funct;
`ifdef MC_WAIT_STATE_EN
   logic           mem_ready;
`endif
   logic           irwrite;
   logic           pcwrite;
   logic           branch;
   logic           iord;
   logic           memwrite;
   logic           alusrca;
   logic [1:0]     alusrcb;
   logic [1:0]     pcsrc;
   logic [3:0]     aluop;
   logic           sextend;
   logic           regdst;
   logic           memtoreg;
   logic           regwrite;
   logic           illegal;
   logic [SW-1:0]  state;

   modport master (
      input  op, funct,
`ifdef MC_WAIT_STATE_EN
      input  mem_ready,
`endif
      output irwrite, pcwrite, branch, iord, memwrite, alusrca, alusrcb, pcsrc,
      output aluop, sextend, regdst, memtoreg, regwrite, illegal, state
   );

   modport slave (
      output op, funct,
`ifdef MC_WAIT_STATE_EN
      output mem_ready,
`endif
      input  irwrite, pcwrite, branch, iord, memwrite, alusrca, alusrcb, pcsrc,
      input  aluop, sextend, regdst, memtoreg, regwrite, illegal, state
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM: sequences each instruction over a shared ALU and unified memory.
// Optional memory wait states are enabled with the MC_WAIT_STATE_EN macro.
module mc_control_fsm #(
   parameter int OPW = 6,
   parameter int SW  = 4
) (
   input  logic          clk,
   input  logic          reset,
   mc_control_fsm_if.master bus
);

   typedef enum logic [SW-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REX    = 4'd6,
      S_ALUWB  = 4'd7,
      S_BEQ    = 4'd8,
      S_IEX    = 4'd9,
      S_JMP    = 4'd10
   } state_e;

   typedef struct packed {
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [3:0] aluop;
      logic       sextend;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
   } ctrl_t;

   localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPW-1:0] OP_J     = 6'b000010;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
   localparam logic [OPW-1:0] OP_LW    = 6'b100011;
   localparam logic [OPW-1:0] OP_SW    = 6'b101011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   iex_q, iex_d;
   logic   mem_ok;

   function automatic logic funct_ok(input logic [OPW-1:0] f);
      case (f)
         6'b100000, 6'b100010, 6'b100100,
         6'b100101, 6'b101010, 6'b100111: funct_ok = 1'b1;
         default:                         funct_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] rtype_aluop(input logic [OPW-1:0] f);
      case (f)
         6'b100010: rtype_aluop = ALU_SUB;
         6'b100100: rtype_aluop = ALU_AND;
         6'b100101: rtype_aluop = ALU_OR;
         6'b101010: rtype_aluop = ALU_SLT;
         6'b100111: rtype_aluop = ALU_NOR;
         default:   rtype_aluop = ALU_ADD;
      endcase
   endfunction

   // Control word of a state; the FSM registers the word of the state it is entering.
   function automatic ctrl_t decode_ctrl(input state_e s, input logic [OPW-1:0] o,
                                         input logic [OPW-1:0] f, input logic iex);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alusrcb = 2'b01; c.aluop = ALU_ADD; c.irwrite = 1'b1; c.pcwrite = 1'b1;
         end
         S_DECODE: begin
            c.alusrcb = 2'b11; c.aluop = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1; c.alusrcb = 2'b10; c.sextend = 1'b1; c.aluop = ALU_ADD;
         end
         S_MEMRD: c.iord = 1'b1;
         S_MEMWB: begin
            c.memtoreg = 1'b1; c.regwrite = 1'b1;
         end
         S_MEMWR: begin
            c.iord = 1'b1; c.memwrite = 1'b1;
         end
         S_REX: begin
            c.alusrca = 1'b1; c.alusrcb = 2'b00; c.aluop = rtype_aluop(f);
         end
         S_ALUWB: begin
            c.regdst = ~iex; c.regwrite = 1'b1;
         end
         S_BEQ: begin
            c.alusrca = 1'b1; c.aluop = ALU_SUB; c.pcsrc = 2'b01; c.branch = 1'b1;
         end
         S_IEX: begin
            c.alusrca = 1'b1; c.alusrcb = 2'b10;
            case (o)
               OP_SLTI: begin c.aluop = ALU_SLT; c.sextend = 1'b1; end
               OP_ANDI: begin c.aluop = ALU_AND; c.sextend = 1'b0; end
               OP_ORI:  begin c.aluop = ALU_OR;  c.sextend = 1'b0; end
               default: begin c.aluop = ALU_ADD; c.sextend = 1'b1; end
            endcase
         end
         S_JMP: begin
            c.pcsrc = 2'b10; c.pcwrite = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

`ifdef MC_WAIT_STATE_EN
   assign mem_ok = bus.mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:                      state_d = S_MEMADR;
               OP_RTYPE:                          state_d = funct_ok(bus.funct) ? S_REX : S_FETCH;
               OP_BEQ:                            state_d = S_BEQ;
               OP_J:                              state_d = S_JMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEX;
               default:                           state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
         S_REX:    state_d = S_ALUWB;
         S_IEX:    state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
      iex_d  = (state_q == S_IEX) | (iex_q & (state_q != S_FETCH));
      ctrl_d = decode_ctrl(state_d, bus.op, bus.funct, iex_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_ctrl(S_FETCH, bus.op, bus.funct, 1'b0);
         iex_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         iex_q   <= iex_d;
      end
   end

   // Outputs are forced low while reset is held; FETCH strobes wait for the memory.
   assign bus.irwrite  = ~reset & ctrl_q.irwrite & mem_ok;
   assign bus.pcwrite  = ~reset & ctrl_q.pcwrite & (mem_ok | (state_q != S_FETCH));
   assign bus.branch   = ~reset & ctrl_q.branch;
   assign bus.iord     = ~reset & ctrl_q.iord;
   assign bus.memwrite = ~reset & ctrl_q.memwrite;
   assign bus.alusrca  = ~reset & ctrl_q.alusrca;
   assign bus.alusrcb  = reset ? 2'b00 : ctrl_q.alusrcb;
   assign bus.pcsrc    = reset ? 2'b00 : ctrl_q.pcsrc;
   assign bus.aluop    = reset ? 4'b0000 : ctrl_q.aluop;
   assign bus.sextend  = ~reset & ctrl_q.sextend;
   assign bus.regdst   = ~reset & ctrl_q.regdst;
   assign bus.memtoreg = ~reset & ctrl_q.memtoreg;
   assign bus.regwrite = ~reset & ctrl_q.regwrite;
   assign bus.state    = reset ? '0 : state_q;
   // The IR loads at the end of FETCH, so the illegal flag decodes the live opcode in DECODE.
   assign bus.illegal  = ~reset & (state_q == S_DECODE) &
                         ~((bus.op == OP_RTYPE) ? funct_ok(bus.funct) :
                           (bus.op inside {OP_LW, OP_SW, OP_BEQ, OP_J,
                                           OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI}));

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed cases plus random instruction streams
// compared cycle by cycle against an instruction-level reference model.
module tb_mc_control_fsm;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mc_control_fsm_if #(.OPW(6), .SW(4)) bus ();
   mc_control_fsm #(.OPW(6), .SW(4)) dut (.clk(clk), .reset(reset), .bus(bus.master));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [22:0] observed();
      return {bus.state, bus.illegal, bus.irwrite, bus.pcwrite, bus.branch, bus.iord,
              bus.memwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop, bus.sextend,
              bus.regdst, bus.memtoreg, bus.regwrite};
   endfunction

   // Expected outputs while an instruction (o,f) occupies state st.
   function automatic logic [22:0] model(input int st, input logic [5:0] o, input logic [5:0] f,
                                         input bit imm, input bit ill);
      logic irw = 0, pcw = 0, br = 0, iord = 0, mw = 0, asa = 0, sx = 0, rd = 0, m2r = 0, rw = 0;
      logic [1:0] asb = 0, pcs = 0;
      logic [3:0] alu = 0;
      logic [3:0] s4 = st[3:0];
      case (st)
         0: begin asb = 1; alu = 4'b0010; irw = 1; pcw = 1; end
         1: begin asb = 3; alu = 4'b0010; end
         2: begin asa = 1; asb = 2; sx = 1; alu = 4'b0010; end
         3: iord = 1;
         4: begin m2r = 1; rw = 1; end
         5: begin iord = 1; mw = 1; end
         6: begin
            asa = 1;
            alu = (f == 6'b100000) ? 4'b0010 : (f == 6'b100010) ? 4'b0110 :
                  (f == 6'b100100) ? 4'b0000 : (f == 6'b100101) ? 4'b0001 :
                  (f == 6'b101010) ? 4'b0111 : 4'b1100;
         end
         7: begin rd = !imm; rw = 1; end
         8: begin asa = 1; alu = 4'b0110; pcs = 1; br = 1; end
         9: begin
            asa = 1; asb = 2;
            if (o == 6'b001000) begin alu = 4'b0010; sx = 1; end
            else if (o == 6'b001010) begin alu = 4'b0111; sx = 1; end
            else if (o == 6'b001100) alu = 4'b0000;
            else alu = 4'b0001;
         end
         10: begin pcs = 2; pcw = 1; end
         default: ;
      endcase
      return {s4, (st == 1) && ill, irw, pcw, br, iord, mw, asa, asb, pcs, alu, sx, rd, m2r, rw};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called in the low phase of a FETCH cycle; returns in the low phase of the next FETCH.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
      int tr[$];
      bit imm = 0, ill = 0;
      bus.op = o;
      bus.funct = f;
      case (o)
         6'b100011: tr = '{0, 1, 2, 3, 4};
         6'b101011: tr = '{0, 1, 2, 5};
         6'b000000: begin
            if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111})
               tr = '{0, 1, 6, 7};
            else begin tr = '{0, 1}; ill = 1; end
         end
         6'b000100: tr = '{0, 1, 8};
         6'b000010: tr = '{0, 1, 10};
         6'b001000, 6'b001010, 6'b001100, 6'b001101: begin tr = '{0, 1, 9, 7}; imm = 1; end
         default: begin tr = '{0, 1}; ill = 1; end
      endcase
      foreach (tr[k]) begin
         #1;
         chk($sformatf("op%b_f%b_cyc%0d", o, f, k), 32'(observed()), 32'(model(tr[k], o, f, imm, ill)));
         @(negedge clk);
      end
   endtask

   initial begin
      logic [5:0] ops[10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                              6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b111111};
      logic [5:0] fns[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
      int wcnt;
      bus.op = 6'b100011;
      bus.funct = 6'b000000;
`ifdef MC_WAIT_STATE_EN
      bus.mem_ready = 1'b1;
`endif
      // Reset held for three cycles: every output low.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk($sformatf("reset_cyc%0d", i), 32'(observed()), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("after_reset_fetch", {28'd0, bus.irwrite, bus.pcwrite, bus.alusrcb}, {28'd0, 1'b1, 1'b1, 2'b01});
      chk("after_reset_aluop", 32'(bus.aluop), 32'b0010);

      // Directed instructions.
      run_instr(6'b100011, 6'b000000);
      run_instr(6'b000000, 6'b100010);
      run_instr(6'b001101, 6'b010101);
      run_instr(6'b001000, 6'b111000);
      run_instr(6'b111111, 6'b000000);
      run_instr(6'b000000, 6'b000011);
      run_instr(6'b101011, 6'b000000);
      run_instr(6'b000100, 6'b000000);
      run_instr(6'b000010, 6'b000000);
      run_instr(6'b001010, 6'b000000);
      run_instr(6'b001100, 6'b000000);
      run_instr(6'b000000, 6'b100111);

      // Reset in the middle of a load returns to FETCH.
      bus.op = 6'b100011;
      @(negedge clk); @(negedge clk);
      #1 chk("mid_lw_state", 32'(bus.state), 32'd2);
      reset = 1'b1;
      #1 chk("mid_lw_reset_outputs", 32'(observed()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("mid_lw_back_to_fetch", 32'(observed()), 32'(model(0, 6'b100011, 6'b0, 0, 0)));

      // Random instruction stream.
      for (int n = 0; n < 250; n++) begin
         logic [5:0] o, f;
         o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
         f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
         run_instr(o, f);
      end
      #1 chk("final_state_fetch", 32'(bus.state), 32'd0);

`ifdef MC_WAIT_STATE_EN
      // Store with three wait cycles in MEMWR.
      bus.op = 6'b101011;
      @(negedge clk); @(negedge clk);
      bus.mem_ready = 1'b0;
      wcnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (bus.memwrite) wcnt++;
         chk($sformatf("wait_memwr_state%0d", i), 32'(bus.state), 32'd5);
      end
      bus.mem_ready = 1'b1;
      #1 if (bus.memwrite) wcnt++;
      chk("wait_memwrite_cycles", 32'(wcnt), 32'd4);
      @(negedge clk);
      #1 chk("wait_back_to_fetch", 32'(bus.state), 32'd0);
      bus.mem_ready = 1'b0;
      #1 chk("wait_fetch_strobes_low", {30'd0, bus.irwrite, bus.pcwrite}, 32'd0);
      @(negedge clk);
      #1 chk("wait_fetch_hold", 32'(bus.state), 32'd0);
      bus.mem_ready = 1'b1;
      #1 chk("wait_fetch_strobes_high", {30'd0, bus.irwrite, bus.pcwrite}, 32'd3);
      // Reset during a MEMWR wait.
      @(negedge clk); @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1 chk("wait2_memwr", {27'd0, bus.state, bus.memwrite}, {27'd0, 4'd5, 1'b1});
      reset = 1'b1;
      #1 chk("wait2_reset_memwrite", 32'(bus.memwrite), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.mem_ready = 1'b1;
      #1 chk("wait2_reset_fetch", {27'd0, bus.state, bus.memwrite}, 32'd0);
`else
      wcnt = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
